fluxo_dados_param: RTL and testbench
====================================

// Module: fluxo_dados_param
// PURPOSE
//  Parametrised datapath for the memory-sequence game, successor to the fixed 4-key/16-entry version.
//  Holds the address counter, a round (limit) counter, a writable sync RAM of stored moves and the
//  registered player move. Also holds the move-edge detector and the timeout counter.
//  Driven by the game control unit; returns compare/status flags plus debug buses for displays.
// PARAMETERS
//  NBOTOES  4     number of keys; width of chaves, jogada and memory word
//  PROF     16    sequence depth (RAM entries, counter modulus); power of 2, >=2
//  TIMEOUT  3000  timeout counter modulus in clocks (>=2)
//  (derived) AW = $clog2(PROF), TW = $clog2(TIMEOUT)
// PORTS
//  clock                in   1   system clock, rising edge
//  reset                in   1   asynchronous, active-low; clears all state except RAM contents
//  chaves               in   NB  raw key levels
//  zeraE, contaE        in   1   address counter: sync clear / increment
//  zeraL, contaL        in   1   limit (round) counter: sync clear / increment
//  zeraR, registraR     in   1   move register: sync clear / load chaves
//  escreveM             in   1   write registered move into RAM[endereco]
//  zera_timer           in   1   timeout counter sync clear
//  conta_timer          in   1   timeout counter enable
//  igual                out  1   RAM word == registered move
//  enderecoIgualLimite  out  1   endereco == limite
//  fimE, fimL           out  1   counter at PROF-1
//  fim_timer            out  1   timeout counter at TIMEOUT-1
//  jogada_feita         out  1   1-cycle pulse: a key press began
//  jogada_valida        out  1   registered move is exactly one-hot
//  db_tem_jogada        out  1   OR of chaves (combinational)
//  db_jogada            out  NB  registered move
//  db_memoria           out  NB  RAM read word
//  db_contagem          out  AW  endereco
//  db_limite            out  AW  limite
// BEHAVIOUR
//  - Reset low: endereco=0, limite=0, jogada=0, RAM read reg=0, timer=0, edge state=0.
//    Hence igual=1, enderecoIgualLimite=1, jogada_feita=0, jogada_valida=0. RAM array is not cleared.
//  - Every counter/register applies clear over enable on the same edge (zeraX wins over contaX/registraR).
//  - Address/limit counters wrap PROF-1 -> 0 on conta; fimE/fimL are combinational on count==PROF-1.
//  - RAM: 1-cycle synchronous read of RAM[endereco]; db_memoria is valid the cycle after endereco settles.
//    On escreveM, RAM[endereco] <= jogada at the edge. Write-first: that same edge also loads the read reg
//    with the written word.
//  - igual and jogada_valida are combinational on the registered values.
//    registraR loads chaves verbatim (multi-key allowed); jogada_valida flags it.
//  - Edge detector: OR(chaves) sampled each clock; jogada_feita=1 for exactly one cycle on 0->1.
//    It does not re-fire while any key stays held. A second key added while one is held gives no pulse.
//  - Timeout: counts while conta_timer=1, holds otherwise, wraps TIMEOUT-1 -> 0.
//    fim_timer is high while count==TIMEOUT-1.
//  - Reset asserted mid-operation: all registers clear immediately (async); jogada_feita is cut short.
//    After reset release, a key already held does not produce a pulse until it is released and pressed again.
//  - No latency other than the RAM read; no X on outputs after reset.
// STRUCTURE
//  - Shared package fluxo_pkg: NBOTOES/PROF/TIMEOUT defaults and the clog2 helper for AW/TW.
//  - Sub-module sync_ram_param (#PROF,#NB): write-first single-port RAM.
//  - Reuse contador_m for both address counters and the timer; reuse edge_detector.
//  - One-hot check is local logic: jogada!=0 && (jogada & (jogada-1))==0.
// TESTING  (NB=4, PROF=16, TIMEOUT=8)
//  - Reset low mid-count (endereco=5, timer=3) -> all counts 0 at once.
//    igual=1 and enderecoIgualLimite=1 after release.
//  - Write 0001,0010,0100,1000 at addr 0..3 (registraR then escreveM), zeraE, step contaE.
//    db_memoria matches each word one cycle after its address; 0010 at addr 1 gives igual=1.
//  - contaE 15 times -> fimE=1 at 15; one more -> endereco=0, fimE=0.
//    zeraE&contaE together -> 0.
//  - chaves 0000->0100 held 5 cycles -> jogada_feita one pulse.
//    Adding 0001 while held -> no pulse; release then 0010 -> new pulse.
//  - registraR with chaves=0110 -> jogada_valida=0; with 0100 -> 1.
//  - conta_timer=1 for 7 cycles -> fim_timer=1; next cycle count=0, fim_timer=0.
//    zera_timer at count 4 -> 0.

Source files
------------

// File: rtl/fluxo_pkg.sv
// Shared defaults and width helper for the parametrised game datapath.
package fluxo_pkg;

    localparam int NBOTOES_DEF = 4;
    localparam int PROF_DEF    = 16;
    localparam int TIMEOUT_DEF = 3000;

    // Counter width for a given modulus; never narrower than one bit.
    function automatic int largura(input int modulo);
        return (modulo < 2) ? 1 : $clog2(modulo);
    endfunction

endpackage

// File: rtl/contador_m.sv
// Modulo-M up-counter with synchronous clear that wins over the count enable.
module contador_m #(
    parameter int M = 16,
    parameter int N = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         zera,
    input  logic         conta,
    output logic [N-1:0] q
);

    localparam logic [N-1:0] ULTIMO = N'(M - 1);

    // Count register: clear first, otherwise step and wrap at M-1.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else if (zera) begin
            q <= '0;
        end else if (conta) begin
            if (q == ULTIMO) begin
                q <= '0;
            end else begin
                q <= q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/edge_detector.sv
// Rising-edge pulse on a level input. After reset the detector stays disarmed
// until the input has been seen low once, so a key already held while reset
// is released does not count as a fresh press.
module edge_detector (
    input  logic clock,
    input  logic reset,
    input  logic sinal,
    output logic pulso
);

    logic anterior;
    logic armado;

    // Previous level and arm flag; arming happens on the first idle sample.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            anterior <= 1'b0;
            armado   <= 1'b0;
        end else begin
            anterior <= sinal;
            if (!sinal) begin
                armado <= 1'b1;
            end
        end
    end

    assign pulso = sinal & ~anterior & armado;

endmodule

// File: rtl/sync_ram_param.sv
// Single-port RAM with a registered read port. A write also loads the read
// register with the written word, so the new value is visible next cycle.
module sync_ram_param #(
    parameter int PROF = 16,
    parameter int NB   = 4,
    parameter int AW   = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [NB-1:0] din,
    output logic [NB-1:0] dout
);

    logic [NB-1:0] mem [PROF];

    // Storage array: no reset so it maps onto plain RAM.
    always_ff @(posedge clock) begin
        if (we) begin
            mem[addr] <= din;
        end
    end

    // Read register: write-first, cleared by reset independently of the array.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            dout <= '0;
        end else if (we) begin
            dout <= din;
        end else begin
            dout <= mem[addr];
        end
    end

endmodule

// File: rtl/fluxo_dados_param.sv
// Datapath of the memory-sequence game: address and round counters, move
// memory, registered player move, key-press edge detector and timeout timer.
module fluxo_dados_param
    import fluxo_pkg::*;
#(
    parameter int NBOTOES = NBOTOES_DEF,
    parameter int PROF    = PROF_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NBOTOES-1:0]         chaves,
    input  logic                       zeraE,
    input  logic                       contaE,
    input  logic                       zeraL,
    input  logic                       contaL,
    input  logic                       zeraR,
    input  logic                       registraR,
    input  logic                       escreveM,
    input  logic                       zera_timer,
    input  logic                       conta_timer,
    output logic                       igual,
    output logic                       enderecoIgualLimite,
    output logic                       fimE,
    output logic                       fimL,
    output logic                       fim_timer,
    output logic                       jogada_feita,
    output logic                       jogada_valida,
    output logic                       db_tem_jogada,
    output logic [NBOTOES-1:0]         db_jogada,
    output logic [NBOTOES-1:0]         db_memoria,
    output logic [largura(PROF)-1:0]   db_contagem,
    output logic [largura(PROF)-1:0]   db_limite
);

    localparam int AW = largura(PROF);
    localparam int TW = largura(TIMEOUT);

    localparam logic [AW-1:0] ULTIMO_END   = AW'(PROF - 1);
    localparam logic [TW-1:0] ULTIMO_TIMER = TW'(TIMEOUT - 1);

    logic [AW-1:0]      endereco;
    logic [AW-1:0]      limite;
    logic [TW-1:0]      timer;
    logic [NBOTOES-1:0] jogada;
    logic [NBOTOES-1:0] memoria;
    logic               tem_jogada;

    assign tem_jogada = |chaves;

    contador_m #(.M(PROF), .N(AW)) u_cont_end (
        .clock (clock),
        .reset (reset),
        .zera  (zeraE),
        .conta (contaE),
        .q     (endereco)
    );

    contador_m #(.M(PROF), .N(AW)) u_cont_lim (
        .clock (clock),
        .reset (reset),
        .zera  (zeraL),
        .conta (contaL),
        .q     (limite)
    );

    contador_m #(.M(TIMEOUT), .N(TW)) u_timer (
        .clock (clock),
        .reset (reset),
        .zera  (zera_timer),
        .conta (conta_timer),
        .q     (timer)
    );

    // Player move register: clear wins over load; keys are latched verbatim.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            jogada <= '0;
        end else if (zeraR) begin
            jogada <= '0;
        end else if (registraR) begin
            jogada <= chaves;
        end
    end

    sync_ram_param #(.PROF(PROF), .NB(NBOTOES), .AW(AW)) u_ram (
        .clock (clock),
        .reset (reset),
        .we    (escreveM),
        .addr  (endereco),
        .din   (jogada),
        .dout  (memoria)
    );

    edge_detector u_borda (
        .clock (clock),
        .reset (reset),
        .sinal (tem_jogada),
        .pulso (jogada_feita)
    );

    assign igual               = (memoria == jogada);
    assign enderecoIgualLimite = (endereco == limite);
    assign fimE                = (endereco == ULTIMO_END);
    assign fimL                = (limite == ULTIMO_END);
    assign fim_timer           = (timer == ULTIMO_TIMER);

    // A move is valid only when exactly one key was latched.
    assign jogada_valida = (jogada != '0) &&
                           ((jogada & (jogada - NBOTOES'(1))) == '0);

    assign db_tem_jogada = tem_jogada;
    assign db_jogada     = jogada;
    assign db_memoria    = memoria;
    assign db_contagem   = endereco;
    assign db_limite     = limite;

endmodule

// File: tb/tb_fluxo_dados_param.sv
// Bench for fluxo_dados_param: directed scenarios with literal checks, then
// randomized control traffic checked every cycle against a behavioural model.
module tb_fluxo_dados_param;

    localparam int NB   = 4;
    localparam int PROF = 16;
    localparam int TO   = 8;
    localparam int AW   = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic [NB-1:0] chaves = '0;
    logic zeraE = 1'b0, contaE = 1'b0, zeraL = 1'b0, contaL = 1'b0;
    logic zeraR = 1'b0, registraR = 1'b0, escreveM = 1'b0;
    logic zera_timer = 1'b0, conta_timer = 1'b0;

    logic          igual, enderecoIgualLimite, fimE, fimL, fim_timer;
    logic          jogada_feita, jogada_valida, db_tem_jogada;
    logic [NB-1:0] db_jogada, db_memoria;
    logic [AW-1:0] db_contagem, db_limite;

    fluxo_dados_param #(.NBOTOES(NB), .PROF(PROF), .TIMEOUT(TO)) dut (
        .clock               (clock),
        .reset               (reset),
        .chaves              (chaves),
        .zeraE               (zeraE),
        .contaE              (contaE),
        .zeraL               (zeraL),
        .contaL              (contaL),
        .zeraR               (zeraR),
        .registraR           (registraR),
        .escreveM            (escreveM),
        .zera_timer          (zera_timer),
        .conta_timer         (conta_timer),
        .igual               (igual),
        .enderecoIgualLimite (enderecoIgualLimite),
        .fimE                (fimE),
        .fimL                (fimL),
        .fim_timer           (fim_timer),
        .jogada_feita        (jogada_feita),
        .jogada_valida       (jogada_valida),
        .db_tem_jogada       (db_tem_jogada),
        .db_jogada           (db_jogada),
        .db_memoria          (db_memoria),
        .db_contagem         (db_contagem),
        .db_limite           (db_limite)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // Behavioural model state.
    int            m_end = 0;
    int            m_lim = 0;
    int            m_tmr = 0;
    logic [NB-1:0] m_jog = '0;
    logic [NB-1:0] m_mem [PROF];
    bit            m_memv [PROF];
    logic [NB-1:0] m_rd = '0;
    bit            m_rdv = 1'b1;
    // Reset counts as "a key may be held": a press only counts after a release.
    bit            m_prev_any = 1'b1;

    task automatic pin(input string nome, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nome, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Model update: same rules as the datapath, expressed as plain arithmetic.
    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_end = 0; m_lim = 0; m_tmr = 0; m_jog = '0;
            m_rd = '0; m_rdv = 1'b1; m_prev_any = 1'b1;
        end else begin
            if (escreveM) begin
                m_mem[m_end]  = m_jog;
                m_memv[m_end] = 1'b1;
                m_rd  = m_jog;
                m_rdv = 1'b1;
            end else begin
                m_rd  = m_mem[m_end];
                m_rdv = m_memv[m_end];
            end
            m_end = zeraE ? 0 : (contaE ? (m_end + 1) % PROF : m_end);
            m_lim = zeraL ? 0 : (contaL ? (m_lim + 1) % PROF : m_lim);
            m_tmr = zera_timer ? 0 : (conta_timer ? (m_tmr + 1) % TO : m_tmr);
            m_jog = zeraR ? '0 : (registraR ? chaves : m_jog);
            m_prev_any = (chaves != '0);
        end
    end

    // Compare every output against the model on the falling edge.
    always @(negedge clock) begin
        if (chk_en) begin
            pin("contagem", 32'(db_contagem), 32'(m_end));
            pin("limite", 32'(db_limite), 32'(m_lim));
            pin("fimE", 32'(fimE), 32'(m_end == PROF - 1));
            pin("fimL", 32'(fimL), 32'(m_lim == PROF - 1));
            pin("end_eq_lim", 32'(enderecoIgualLimite), 32'(m_end == m_lim));
            pin("fim_timer", 32'(fim_timer), 32'(m_tmr == TO - 1));
            pin("jogada", 32'(db_jogada), 32'(m_jog));
            pin("valida", 32'(jogada_valida), 32'($countones(m_jog) == 1));
            pin("tem_jogada", 32'(db_tem_jogada), 32'(chaves != '0));
            pin("jogada_feita", 32'(jogada_feita),
                32'((reset == 1'b1) && (chaves != '0) && !m_prev_any));
            if (m_rdv) begin
                pin("memoria", 32'(db_memoria), 32'(m_rd));
                pin("igual", 32'(igual), 32'(m_rd == m_jog));
            end
        end
    end

    initial begin
        chk_en = 1'b1;
        cyc(2);
        reset = 1'b1;
        cyc(1);
        pin("rst_contagem", 32'(db_contagem), 32'd0);
        pin("rst_igual", 32'(igual), 32'd1);
        pin("rst_eq_lim", 32'(enderecoIgualLimite), 32'd1);
        pin("rst_feita", 32'(jogada_feita), 32'd0);

        // Reset in the middle of counting.
        contaE = 1'b1; conta_timer = 1'b1;
        cyc(3);
        conta_timer = 1'b0;
        cyc(2);
        contaE = 1'b0;
        pin("pre_rst_cont", 32'(db_contagem), 32'd5);
        reset = 1'b0;
        #1;
        pin("async_rst_cont", 32'(db_contagem), 32'd0);
        pin("async_rst_jog", 32'(db_jogada), 32'd0);
        cyc(1);
        reset = 1'b1;
        cyc(1);
        pin("post_rst_igual", 32'(igual), 32'd1);
        pin("post_rst_eq", 32'(enderecoIgualLimite), 32'd1);

        // Store four one-hot moves at addresses 0..3.
        zeraE = 1'b1; cyc(1); zeraE = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chaves = NB'(1 << i);
            registraR = 1'b1; cyc(1); registraR = 1'b0;
            escreveM = 1'b1;  cyc(1); escreveM = 1'b0;
            contaE = 1'b1;    cyc(1); contaE = 1'b0;
        end
        chaves = '0;

        // Read them back one cycle after each address settles.
        zeraE = 1'b1; cyc(1); zeraE = 1'b0;
        cyc(1);
        for (int i = 0; i < 4; i++) begin
            pin("rd_word", 32'(db_memoria), 32'(1 << i));
            if (i == 1) begin
                chaves = 4'b0010;
                registraR = 1'b1; cyc(1); registraR = 1'b0;
                chaves = '0;
                pin("rd_igual", 32'(igual), 32'd1);
            end
            contaE = 1'b1; cyc(1); contaE = 1'b0;
            cyc(1);
        end

        // Address wrap and clear-over-count.
        zeraE = 1'b1; cyc(1); zeraE = 1'b0;
        contaE = 1'b1;
        cyc(15);
        pin("wrap_15", 32'(db_contagem), 32'd15);
        pin("wrap_fimE", 32'(fimE), 32'd1);
        cyc(1);
        contaE = 1'b0;
        pin("wrap_0", 32'(db_contagem), 32'd0);
        pin("wrap_fimE0", 32'(fimE), 32'd0);
        contaE = 1'b1; cyc(3);
        zeraE = 1'b1; cyc(1);
        zeraE = 1'b0; contaE = 1'b0;
        pin("zera_wins", 32'(db_contagem), 32'd0);

        // Key-press edge detection.
        chaves = '0; cyc(2);
        chaves = 4'b0100; #1;
        pin("edge_first", 32'(jogada_feita), 32'd1);
        cyc(1);
        pin("edge_held", 32'(jogada_feita), 32'd0);
        cyc(3);
        chaves = 4'b0101; #1;
        pin("edge_second_key", 32'(jogada_feita), 32'd0);
        cyc(2);
        chaves = '0; cyc(1);
        chaves = 4'b0010; #1;
        pin("edge_again", 32'(jogada_feita), 32'd1);
        cyc(1);
        chaves = '0; cyc(1);

        // One-hot validity.
        chaves = 4'b0110; registraR = 1'b1; cyc(1); registraR = 1'b0;
        pin("valida_0110", 32'(jogada_valida), 32'd0);
        chaves = 4'b0100; registraR = 1'b1; cyc(1); registraR = 1'b0;
        chaves = '0;
        pin("valida_0100", 32'(jogada_valida), 32'd1);

        // Timeout counter.
        zera_timer = 1'b1; cyc(1); zera_timer = 1'b0;
        conta_timer = 1'b1;
        cyc(6);
        pin("timer_6", 32'(fim_timer), 32'd0);
        cyc(1);
        pin("timer_7", 32'(fim_timer), 32'd1);
        cyc(1);
        pin("timer_wrap", 32'(fim_timer), 32'd0);
        cyc(4);
        zera_timer = 1'b1; cyc(1); zera_timer = 1'b0;
        cyc(6);
        pin("timer_after_zera6", 32'(fim_timer), 32'd0);
        cyc(1);
        pin("timer_after_zera7", 32'(fim_timer), 32'd1);
        conta_timer = 1'b0;
        cyc(2);
        pin("timer_hold", 32'(fim_timer), 32'd1);

        // Randomized traffic, model-checked every cycle.
        for (int k = 0; k < 3000; k++) begin
            zeraE       = ($urandom_range(0, 15) == 0);
            contaE      = 1'($urandom_range(0, 1));
            zeraL       = ($urandom_range(0, 31) == 0);
            contaL      = ($urandom_range(0, 3) == 0);
            zeraR       = ($urandom_range(0, 15) == 0);
            registraR   = ($urandom_range(0, 3) == 0);
            escreveM    = ($urandom_range(0, 3) == 0);
            zera_timer  = ($urandom_range(0, 31) == 0);
            conta_timer = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) == 0) begin
                chaves = ($urandom_range(0, 1) == 0) ? '0 : NB'($urandom_range(0, 15));
            end
            reset = ($urandom_range(0, 199) != 0);
            cyc(1);
        end

        reset = 1'b1;
        zeraE = 1'b0; contaE = 1'b0; zeraL = 1'b0; contaL = 1'b0;
        zeraR = 1'b0; registraR = 1'b0; escreveM = 1'b0;
        zera_timer = 1'b0; conta_timer = 1'b0; chaves = '0;
        cyc(2);
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
